// File: rtl/deser1to8_pkg.sv
// Shared constants for the 1-to-8 deserialiser; lane count and slot index
// width match the 8-to-1 time-multiplexer family.
package deser1to8_pkg;

    localparam int LANES     = 8;
    localparam int SLOT_BITS = 3;

endpackage

// File: rtl/deser1to8.sv
// Collects WIDTH-bit serial words into 8-lane parallel frames (lane 0 = first
// word). An assembly bank plus an output bank give 1 word/clock throughput.
module deser1to8
    import deser1to8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 valid_i,
    input  logic                 sync_i,
    output logic                 ready_o,
    output logic [WIDTH-1:0]     data0_o,
    output logic [WIDTH-1:0]     data1_o,
    output logic [WIDTH-1:0]     data2_o,
    output logic [WIDTH-1:0]     data3_o,
    output logic [WIDTH-1:0]     data4_o,
    output logic [WIDTH-1:0]     data5_o,
    output logic [WIDTH-1:0]     data6_o,
    output logic [WIDTH-1:0]     data7_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [SLOT_BITS-1:0] slot_o
);

    localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(LANES - 1);

    logic [SLOT_BITS-1:0] cnt;
    logic [WIDTH-1:0]     asm_bank [LANES];
    logic [WIDTH-1:0]     out_bank [LANES];
    logic                 asm_full;
    logic                 out_valid;

    logic                 accept;
    logic                 pop;
    logic [SLOT_BITS-1:0] slot;
    logic                 complete;
    logic                 load_direct;
    logic                 park;
    logic                 load_pending;

    assign ready_o      = ~asm_full;
    assign accept       = valid_i & ~asm_full;
    assign pop          = out_valid & ready_i;
    // sync_i forces the current word into lane 0 regardless of the counter
    assign slot         = sync_i ? '0 : cnt;
    assign complete     = accept & (slot == LAST_SLOT);
    assign load_direct  = complete & (~out_valid | pop);
    assign park         = complete & ~load_direct;
    assign load_pending = asm_full & pop;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= complete ? '0 : slot + SLOT_BITS'(1);
        end else if (sync_i) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            asm_full  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (park) begin
                asm_full <= 1'b1;
            end else if (load_pending) begin
                asm_full <= 1'b0;
            end

            if (load_direct || load_pending) begin
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Lane 7 is written into the assembly bank only when the frame has to
    // wait; otherwise it bypasses straight into the output bank.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < LANES; i++) begin
                asm_bank[i] <= '0;
                out_bank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES - 1; i++) begin
                if (accept && slot == SLOT_BITS'(i)) begin
                    asm_bank[i] <= data_i;
                end
            end
            if (park) begin
                asm_bank[LANES-1] <= data_i;
            end

            if (load_direct) begin
                for (int i = 0; i < LANES - 1; i++) begin
                    out_bank[i] <= asm_bank[i];
                end
                out_bank[LANES-1] <= data_i;
            end else if (load_pending) begin
                for (int i = 0; i < LANES; i++) begin
                    out_bank[i] <= asm_bank[i];
                end
            end
        end
    end

    assign valid_o = out_valid;
    assign slot_o  = cnt;
    assign data0_o = out_bank[0];
    assign data1_o = out_bank[1];
    assign data2_o = out_bank[2];
    assign data3_o = out_bank[3];
    assign data4_o = out_bank[4];
    assign data5_o = out_bank[5];
    assign data6_o = out_bank[6];
    assign data7_o = out_bank[7];

endmodule

// File: doc/deser1to8.md
Name: deser1to8

Overview:
- Inverse of the 8-to-1 time-multiplexer: collects a serial stream of WIDTH-bit words and presents every 8 consecutive words as one parallel frame on 8 output lanes.
- The first word of a frame goes to lane 0, matching mux select 0, and so on.
- Sits on the receive side of the lane-serialised video/data paths.
- Valid/ready on both sides; double-banked (assembly bank plus output bank) so it sustains 1 word/clock.

Parameters:
WIDTH, 8, bit width of each word and of each output lane.

Ports:
clock_i  in  1  system clock; all state on the rising edge.
reset_i  in  1  asynchronous, active-high reset.
data_i  in  WIDTH  serial input word.
valid_i  in  1  data_i is valid.
sync_i  in  1  qualifies the current input word as the first of a frame (lane 0).
ready_o  out  1  block can accept data_i this cycle.
data0_o..data7_o  out  WIDTH each  parallel frame lanes; data0_o holds the earliest word.
valid_o  out  1  a complete frame is held on data0_o..data7_o.
ready_i  in  1  consumer accepts the frame.
slot_o  out  3  lane index the next accepted word will fill (debug/alignment).

Behaviour:
- Internal state:
  - slot counter cnt[2:0]
  - assembly bank asm[0..7]
  - output bank out[0..7]
  - flag asm_full
  - flag valid_o
- Definitions: accept = valid_i & ready_o; pop = valid_o & ready_i; ready_o = ~asm_full (combinational); slot_o = cnt.
- Reset (asynchronous, reset_i high):
  - cnt=0, asm_full=0, valid_o=0.
  - All asm/out lanes = 0, so data*_o = 0.
  - ready_o=1.
- Slot index k = 0 if sync_i is high on accept, else cnt.
- Accept with k<7:
  - asm[k] <= data_i; cnt <= k+1.
- Accept with k==7 (frame complete):
  - cnt <= 0.
  - If (~valid_o | pop): out <= asm with lane 7 = data_i; valid_o <= 1.
  - Otherwise: asm[7] <= data_i and asm_full <= 1, which drops ready_o next cycle.
- asm_full & pop: out <= asm; valid_o stays 1; asm_full <= 0.
- pop with no load this cycle: valid_o <= 0.
- Latency: valid_o is high the clock after the 8th word is accepted, if the output bank is free.
- Throughput: with ready_i held high, valid_i held high gives one frame every 8 clocks, with no bubbles.
- sync_i without accept: cnt <= 0; the partial frame in asm is discarded (lanes not cleared). asm_full, out and valid_o are unaffected.
- sync_i with accept: the word lands in lane 0 and cnt <= 1, including when cnt was mid-frame.
- sync_i while asm_full: cnt is already 0; the assembled frame is kept and no words are accepted (ready_o=0).
- out lanes change only on a load; they are stable while valid_o & ~ready_i.
- valid_o is not lowered by the producer stalling.
- Reset mid-frame or mid-stall: everything returns to reset values immediately; partial and pending frames are lost.
- cnt wraps 7->0 only on frame completion.

Decomposition:
- Shared include/package: localparam LANES=8 and SLOT_BITS=3. The data0_o..data7_o port list stays flat to match the mux family.
- No sub-module required. Optionally the 8-lane bank can be a generate loop of WIDTH-bit enable registers inside the module.

Test Plan:
1. Reset, then ready_i=1. Feed words 0x10..0x17 with valid_i held high. Required: valid_o high one clock after 0x17 is accepted; data0_o=0x10 … data7_o=0x17; slot_o sequence 0..7,0; ready_o never low.
2. Back-to-back frames 0x20..0x27 and 0x30..0x37 with ready_i=1. Required: second frame's valid_o exactly 8 clocks after the first; no gaps.
3. ready_i=0. Send three frames (0x40.., 0x50.., 0x60..). Required:
   - First frame latched.
   - Second frame held in asm; ready_o low after 0x57.
   - 0x60 not accepted.
   - Raise ready_i for one clock: out becomes 0x50..0x57 and ready_o returns high.
4. Misalignment: send 0xA0,0xA1,0xA2, then 0xB0..0xB7 with sync_i on 0xB0. Required: output frame is 0xB0..0xB7 in lanes 0..7; 0xA* never appears.
5. Pulse sync_i with valid_i=0 after 5 words. Required: slot_o=0; the next 8 words form the frame.
6. Assert reset_i asynchronously (between edges) while asm_full=1 and valid_o=1. Required: valid_o=0, ready_o=1, slot_o=0 and all lanes 0 before the next clock edge.
